// File: rtl/exec_stage_mc_if.sv
// exec_stage_mc_if: ID/EX-facing request and EX/MEM-facing result bundle for exec_stage_mc.
interface exec_stage_mc_if #(parameter int DATA_W = 32, parameter int IMM_W = 24);
  logic              in_valid, in_ready;
  logic              wbEnIn, memREnIn, memWEnIn, branchTakenIn, ldStatus, imm, carryIn;
  logic              isMul, isMla;
  logic [3:0]        exeCmd;
  logic [DATA_W-1:0] val1, valRm, valAcc, pc;
  logic [11:0]       shifterOperand;
  logic [IMM_W-1:0]  signedImm24;
  logic [3:0]        dest;
  logic              out_valid, wbEnOut, memREnOut, memWEnOut, branchTakenOut;
  logic [DATA_W-1:0] aluRes, exeValRm, branchAddr;
  logic [3:0]        exeDest, status;
  modport master (
    output in_valid, wbEnIn, memREnIn, memWEnIn, branchTakenIn, ldStatus, imm, carryIn,
           isMul, isMla, exeCmd, val1, valRm, valAcc, pc, shifterOperand, signedImm24, dest,
    input  in_ready, out_valid, wbEnOut, memREnOut, memWEnOut, branchTakenOut,
           aluRes, exeValRm, branchAddr, exeDest, status
  );
  modport slave (
    input  in_valid, wbEnIn, memREnIn, memWEnIn, branchTakenIn, ldStatus, imm, carryIn,
           isMul, isMla, exeCmd, val1, valRm, valAcc, pc, shifterOperand, signedImm24, dest,
    output in_ready, out_valid, wbEnOut, memREnOut, memWEnOut, branchTakenOut,
           aluRes, exeValRm, branchAddr, exeDest, status
  );
endinterface

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: registered execute stage with single-cycle ALU and iterative shift-add MUL/MLA.
module exec_stage_mc #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 4,
  parameter int IMM_W    = 24
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  exec_stage_mc_if.slave bus
);
  localparam int MUL_CYC = DATA_W / MUL_STEP;
  localparam int CNT_W   = MUL_CYC > 1 ? $clog2(MUL_CYC) : 1;
  typedef enum logic {IDLE, MUL} state_e;
  typedef struct packed {
    logic              wb, mr, mw, bt;
    logic [3:0]        dest;
    logic [DATA_W-1:0] rm, ba;
  } fields_t;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, step_acc;
  logic              cap_ld_q;
  fields_t           cap_q, out_q, in_f;
  logic              out_valid_q;
  logic [DATA_W-1:0] alu_q;
  logic [3:0]        status_q;
  logic              accept, is_mul, last, ret_alu, ret_mul;
  logic [4:0]        sh, rot;
  logic [DATA_W-1:0] rm, imm_ext, imm_rot, sh_res, val2, bb, alu_res, off;
  logic [DATA_W:0]   sum;
  logic              is_sub, is_arith, cin, valid_cmd, n, z, c, v;
  assign is_mul = bus.isMul | bus.isMla;
  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign last   = cnt_q == CNT_W'(MUL_CYC - 1);
  assign ret_alu = accept && !is_mul;
  assign ret_mul = state_q == MUL && last && !flush;
  // Operand 2: immediate rotate or register shift
  assign rm      = bus.valRm;
  assign sh      = bus.shifterOperand[11:7];
  assign rot     = {bus.shifterOperand[11:8], 1'b0};
  assign imm_ext = {{(DATA_W-8){1'b0}}, bus.shifterOperand[7:0]};
  assign imm_rot = (imm_ext >> rot) | (imm_ext << (DATA_W - int'(rot)));
  assign sh_res  = bus.shifterOperand[6:5] == 2'b00 ? rm << sh :
                   bus.shifterOperand[6:5] == 2'b01 ? rm >> sh :
                   bus.shifterOperand[6:5] == 2'b10 ? $unsigned($signed(rm) >>> sh) :
                   (rm >> sh) | (rm << (DATA_W - int'(sh)));
  assign val2 = (bus.memREnIn | bus.memWEnIn) ? DATA_W'(bus.shifterOperand) :
                bus.imm ? imm_rot : sh_res;
  // Subtraction is a + ~b + cin so C reads as "no borrow"
  assign is_sub   = bus.exeCmd == 4'b0100 || bus.exeCmd == 4'b0101;
  assign is_arith = bus.exeCmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
  assign cin      = (bus.exeCmd == 4'b0011 || bus.exeCmd == 4'b0101) ? bus.carryIn : is_sub;
  assign bb       = is_sub ? ~val2 : val2;
  assign sum      = {1'b0, bus.val1} + {1'b0, bb} + {{DATA_W{1'b0}}, cin};
  always_comb begin
    alu_res = '0;
    case (bus.exeCmd)
      4'b0001:                            alu_res = val2;
      4'b1001:                            alu_res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum[DATA_W-1:0];
      4'b0110:                            alu_res = bus.val1 & val2;
      4'b0111:                            alu_res = bus.val1 | val2;
      4'b1000:                            alu_res = bus.val1 ^ val2;
      default:                            alu_res = '0;
    endcase
  end
  assign valid_cmd = bus.exeCmd inside {[4'b0001:4'b1001]};
  assign n = valid_cmd & alu_res[DATA_W-1];
  assign z = valid_cmd & (alu_res == '0);
  assign c = is_arith & sum[DATA_W];
  assign v = is_arith & (bus.val1[DATA_W-1] == bb[DATA_W-1]) & (alu_res[DATA_W-1] != bus.val1[DATA_W-1]);
  assign off  = DATA_W'($signed(bus.signedImm24));
  assign in_f = '{wb: bus.wbEnIn, mr: bus.memREnIn, mw: bus.memWEnIn, bt: bus.branchTakenIn,
                  dest: bus.dest, rm: bus.valRm, ba: bus.pc + (off << 2)};
  assign step_acc = acc_q + mcand_q * DATA_W'(mplier_q[MUL_STEP-1:0]);
  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && accept && is_mul) state_d = MUL;
    else if (state_q == MUL && last) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cap_q       <= '0;
      cap_ld_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= ret_alu || ret_mul;
      if (accept && is_mul) begin
        mcand_q  <= bus.val1;
        mplier_q <= bus.valRm;
        acc_q    <= bus.isMla ? bus.valAcc : '0;
        cnt_q    <= '0;
        cap_q    <= in_f;
        cap_ld_q <= bus.ldStatus;
      end else if (state_q == MUL) begin
        mcand_q  <= mcand_q << MUL_STEP;
        mplier_q <= mplier_q >> MUL_STEP;
        acc_q    <= step_acc;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (ret_alu) begin
        out_q <= in_f;
        alu_q <= alu_res;
        if (bus.ldStatus) status_q <= {n, z, c, v};
      end else if (ret_mul) begin
        out_q <= cap_q;
        alu_q <= step_acc;
        if (cap_ld_q) status_q <= {step_acc[DATA_W-1], step_acc == '0, status_q[1:0]};
      end
    end
  end
  assign bus.in_ready       = state_q == IDLE;
  assign bus.out_valid      = out_valid_q;
  assign bus.wbEnOut        = out_q.wb;
  assign bus.memREnOut      = out_q.mr;
  assign bus.memWEnOut      = out_q.mw;
  assign bus.branchTakenOut = out_q.bt;
  assign bus.exeDest        = out_q.dest;
  assign bus.exeValRm       = out_q.rm;
  assign bus.branchAddr     = out_q.ba;
  assign bus.aluRes         = alu_q;
  assign bus.status         = status_q;
endmodule
